// File: rtl/mul_div_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_if
//  Description : Request/result bundle between the execute stage and the
//                iterative multiply/divide unit.
//                  start       core -> unit  request pulse
//                  op_div      core -> unit  0 = multiply, 1 = divide
//                  opa / opb   core -> unit  rs / rt operands
//                  busy        unit -> core  operation in progress (stall)
//                  done        unit -> core  one-cycle result-valid pulse
//                  result_lo   unit -> core  product low half or quotient
//                  result_hi   unit -> core  product high half or remainder
//                  div_by_zero unit -> core  last divide had a zero divisor
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_div;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  modport master (
    output start, op_div, opa, opb,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, op_div, opa, opb,
    output busy, done, result_lo, result_hi, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Iterative radix-2 multiply / restoring divide unit.
//                One iteration per clock, WIDTH iterations, then a sign-fix
//                cycle; results registered and held until the next fix.
//  Ports       : clk    rising-edge clock
//                reset  asynchronous active-high reset
//                bus    mul_div_if.slave (start/op_div/opa/opb in,
//                       busy/done/result_lo/result_hi/div_by_zero out)
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  wire        clk,
  input  wire        reset,
  mul_div_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_op_div;
  logic               r_neg_a;
  logic               r_neg_b;
  logic               r_b_zero;
  logic [WIDTH-1:0]   r_orig_a;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic [2*WIDTH-1:0] r_acc;     // multiply: {partial sum, remaining multiplier bits}
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;     // dividend bits shift out as quotient bits shift in
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;

  // Operand magnitudes. -MIN wraps back to MIN, which read unsigned is
  // exactly 2^(WIDTH-1), so the MIN operand needs no special case.
  logic             w_neg_a, w_neg_b;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  assign w_neg_a = SIGNED && bus.opa[WIDTH-1];
  assign w_neg_b = SIGNED && bus.opb[WIDTH-1];
  assign w_mag_a = w_neg_a ? -bus.opa : bus.opa;
  assign w_mag_b = w_neg_b ? -bus.opb : bus.opb;

  // Shift-add step: add the multiplicand when the current multiplier bit is
  // set; the carry lands in the top bit as the accumulator shifts right.
  logic [WIDTH:0] w_mul_sum;
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + {1'b0, (r_acc[0] ? r_mag_a : {WIDTH{1'b0}})};

  // Restoring step on a WIDTH+1 bit working remainder. Since rem < divisor,
  // the trial value is < 2*divisor, so the sign of the difference fits in
  // bit WIDTH and tells whether the subtraction succeeds.
  logic [WIDTH:0] w_trial, w_diff;
  logic           w_ge;
  assign w_trial = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_trial - {1'b0, r_mag_b};
  assign w_ge    = ~w_diff[WIDTH];

  // Sign correction applied in FIX.
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;
  assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
  assign w_quo_fix  = (r_neg_a ^ r_neg_b) ? -r_quo : r_quo;
  assign w_rem_fix  = r_neg_a ? -r_rem : r_rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op_div <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_b_zero <= 1'b0;
      r_orig_a <= '0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_lo     <= '0;
      r_hi     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_op_div <= bus.op_div;
            r_neg_a  <= w_neg_a;
            r_neg_b  <= w_neg_b;
            r_b_zero <= (bus.opb == '0);
            r_orig_a <= bus.opa;
            r_mag_a  <= w_mag_a;
            r_mag_b  <= w_mag_b;
            r_acc    <= {{WIDTH{1'b0}}, w_mag_b};
            r_rem    <= '0;
            r_quo    <= w_mag_a;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_RUN: begin
          if (r_op_div) begin
            r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
          end else begin
            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          if (!r_op_div) begin
            r_lo  <= w_prod_fix[WIDTH-1:0];
            r_hi  <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_dbz <= 1'b0;
          end else if (r_b_zero) begin
            r_lo  <= {WIDTH{1'b1}};
            r_hi  <= r_orig_a;
            r_dbz <= 1'b1;
          end else begin
            r_lo  <= w_quo_fix;
            r_hi  <= w_rem_fix;
            r_dbz <= 1'b0;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.result_lo   = r_lo;
  assign bus.result_hi   = r_hi;
  assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_div_unit
//  Description : Directed, table-driven bench for mul_div_unit. A signed and
//                an unsigned instance receive the same stimulus; each vector
//                selects which instance's results are compared.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;   // edges from the start-sampling edge to done

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_div_if #(.WIDTH(W)) s_if ();
  mul_div_if #(.WIDTH(W)) u_if ();

  mul_div_unit #(.WIDTH(W), .SIGNED(1'b1)) dut_s (.clk(clk), .reset(rst), .bus(s_if.slave));
  mul_div_unit #(.WIDTH(W), .SIGNED(1'b0)) dut_u (.clk(clk), .reset(rst), .bus(u_if.slave));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic s, input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
    s_if.start = s; s_if.op_div = d; s_if.opa = a; s_if.opb = b;
    u_if.start = s; u_if.op_div = d; u_if.opa = a; u_if.opb = b;
  endtask

  // Issues one operation and waits (bounded) for done. lat counts edges
  // after the edge that sampled start.
  task automatic do_op(input logic uns, input logic d, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] lo, output logic [W-1:0] hi, output logic dbz,
                       output int lat, output logic busy_ok);
    @(negedge clk);
    drive(1'b1, d, a, b);
    @(posedge clk); #1;
    drive(1'b0, ~d, $urandom, $urandom);   // operands may change after acceptance
    lat = 0; busy_ok = 1'b1;
    while (!s_if.done && lat < 100) begin
      if (!s_if.busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (s_if.busy) busy_ok = 1'b0;
    lo  = uns ? u_if.result_lo   : s_if.result_lo;
    hi  = uns ? u_if.result_hi   : s_if.result_hi;
    dbz = uns ? u_if.div_by_zero : s_if.div_by_zero;
  endtask

  typedef struct {
    logic         uns;
    logic         d;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  logic [W-1:0] lo, hi;
  logic         dbz, bok;
  int           lat;

  initial begin
    //         uns   div   opa           opb           lo            hi            dbz
    vecs[0]  = '{1'b0, 1'b0, 32'd7,        32'd6,        32'h0000002A, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h12345678, 32'd0,        32'hFFFFFFFF, 32'h12345678, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 32'd2,        32'd2,        32'd4,        32'd0,        1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
    vecs[12] = '{1'b0, 1'b1, 32'd7,        32'd100,      32'd0,        32'd7,        1'b0};
    vecs[13] = '{1'b0, 1'b0, 32'h12345678, 32'h10,       32'h23456780, 32'h00000001, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 32'hFFFFFFF0, 32'h10,       32'h0FFFFFFF, 32'h00000000, 1'b0};

    // ---------------- reset state ----------------
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(s_if.busy), 64'd0);
    check("rst_done", 64'(s_if.done), 64'd0);
    check("rst_lo",   64'(s_if.result_lo), 64'd0);
    check("rst_hi",   64'(s_if.result_hi), 64'd0);
    check("rst_dbz",  64'(s_if.div_by_zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- vector table (consecutive ops start from DONE) ----------------
    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].uns, vecs[i].d, vecs[i].a, vecs[i].b, lo, hi, dbz, lat, bok);
      check($sformatf("v%0d_lat", i),  64'(lat), 64'(LAT));
      check($sformatf("v%0d_busy", i), 64'(bok), 64'd1);
      check($sformatf("v%0d_lo", i),   64'(lo),  64'(vecs[i].lo));
      check($sformatf("v%0d_hi", i),   64'(hi),  64'(vecs[i].hi));
      check($sformatf("v%0d_dbz", i),  64'(dbz), 64'(vecs[i].dbz));
    end

    // ---------------- done is a single-cycle pulse ----------------
    @(posedge clk); #1;
    check("done_pulse", 64'(s_if.done), 64'd0);
    repeat (2) @(posedge clk);

    // ---------------- start while busy is ignored ----------------
    begin
      int n_done, first;
      @(negedge clk);
      drive(1'b1, 1'b0, 32'd7, 32'd6);
      @(posedge clk); #1;                    // edge 0 samples start
      drive(1'b0, 1'b0, '0, '0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      drive(1'b1, 1'b1, 32'd100, 32'd7);
      @(posedge clk); #1;                    // edge 10, unit busy
      drive(1'b0, 1'b0, '0, '0);
      n_done = 0; first = -1;
      for (int e = 11; e <= 70; e++) begin
        @(posedge clk); #1;
        if (s_if.done) begin
          n_done++;
          if (first < 0) begin
            first = e;
            check("ign_lo", 64'(s_if.result_lo), 64'd42);
            check("ign_hi", 64'(s_if.result_hi), 64'd0);
          end
        end
      end
      check("ign_done_count", 64'(n_done), 64'd1);
      check("ign_latency",    64'(first),  64'(LAT));
    end

    // ---------------- reset mid-RUN ----------------
    do_op(1'b0, 1'b1, 32'd5, 32'd0, lo, hi, dbz, lat, bok);
    check("pre_rst_dbz", 64'(dbz), 64'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'd3, 32'd5);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, '0, '0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(s_if.busy), 64'd0);
    check("mid_rst_done", 64'(s_if.done), 64'd0);
    check("mid_rst_lo",   64'(s_if.result_lo), 64'd0);
    check("mid_rst_hi",   64'(s_if.result_hi), 64'd0);
    check("mid_rst_dbz",  64'(s_if.div_by_zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (s_if.done) check("aborted_no_done", 64'(s_if.done), 64'd0);
    end

    do_op(1'b0, 1'b0, 32'd3, 32'd5, lo, hi, dbz, lat, bok);
    check("post_rst_lat", 64'(lat), 64'(LAT));
    check("post_rst_lo",  64'(lo),  64'd15);
    do_op(1'b0, 1'b1, 32'd15, 32'd4, lo, hi, dbz, lat, bok);
    check("b2b_lat", 64'(lat), 64'(LAT));
    check("b2b_lo",  64'(lo),  64'd3);
    check("b2b_hi",  64'(hi),  64'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
